// File: rtl/avmm_instr_sequencer_if.sv
// Avalon-MM bus bundle between the instruction sequencer (master) and a slave.
//
// Transfer rules:
//   - chipselect qualifies read/write; read and write are never high together.
//   - There is no waitrequest.
//   - A write completes in the single cycle that write is high.
//   - A read keeps read high for a fixed 1+READ_WAIT cycles.
//     The master samples readdata on the last of those cycles.
//   - irq is a level-sensitive request from the slave.
interface avmm_instr_sequencer_if #(
    parameter int ADDRESS_SIZE = 32,
    parameter int DATA_SIZE    = 32
);
    logic                    avmaster_chipselect;
    logic                    avmaster_read;
    logic                    avmaster_write;
    logic [ADDRESS_SIZE-1:0] avmaster_address;
    logic [DATA_SIZE-1:0]    avmaster_writedata;
    logic [DATA_SIZE-1:0]    avmaster_readdata;
    logic                    avmaster_irq;

    modport master (
        output avmaster_chipselect,
        output avmaster_read,
        output avmaster_write,
        output avmaster_address,
        output avmaster_writedata,
        input  avmaster_readdata,
        input  avmaster_irq
    );

    modport slave (
        input  avmaster_chipselect,
        input  avmaster_read,
        input  avmaster_write,
        input  avmaster_address,
        input  avmaster_writedata,
        output avmaster_readdata,
        output avmaster_irq
    );
endinterface

// File: rtl/avmm_instr_sequencer.sv
// Instruction-table-driven Avalon-MM master.
// Each table entry is {opcode, address, data}. The sequencer executes entries
// in order until HALT, an illegal opcode, or the end of the table.
module avmm_instr_sequencer #(
    parameter int ADDRESS_SIZE     = 32,
    parameter int DATA_SIZE        = 32,
    parameter int OPCODE_SIZE      = 4,
    parameter int INSTR_SIZE       = 68,
    parameter int INSTR_LIMIT_SIZE = 7,
    parameter int READ_WAIT        = 1,
    parameter int ERR_CNT_SIZE     = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    avmm_instr_sequencer_if.master      avm,
    output logic [DATA_SIZE-1:0]        readdataWatch,
    output logic [INSTR_LIMIT_SIZE-1:0] programCounter,
    input  logic [INSTR_SIZE-1:0]       instructionVector,
    output logic                        simReady,
    output logic                        errorFlag,
    output logic [ERR_CNT_SIZE-1:0]     errorCount,
    output logic [2:0]                  dbg_state_o
);

    localparam logic [OPCODE_SIZE-1:0] OP_NOP        = OPCODE_SIZE'(4'h0);
    localparam logic [OPCODE_SIZE-1:0] OP_WRITE      = OPCODE_SIZE'(4'h1);
    localparam logic [OPCODE_SIZE-1:0] OP_READ       = OPCODE_SIZE'(4'h2);
    localparam logic [OPCODE_SIZE-1:0] OP_READ_CHECK = OPCODE_SIZE'(4'h3);
    localparam logic [OPCODE_SIZE-1:0] OP_WAIT_IRQ   = OPCODE_SIZE'(4'h4);
    localparam logic [OPCODE_SIZE-1:0] OP_DELAY      = OPCODE_SIZE'(4'h5);
    localparam logic [OPCODE_SIZE-1:0] OP_HALT       = OPCODE_SIZE'(4'hF);

    localparam logic [DATA_SIZE-1:0] CNT_ONE       = DATA_SIZE'(1);
    localparam logic [DATA_SIZE-1:0] READ_WAIT_CNT = DATA_SIZE'(READ_WAIT);

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_WRITE    = 3'd1,
        S_READ     = 3'd2,
        S_WAIT_IRQ = 3'd3,
        S_DELAY    = 3'd4,
        S_HALT     = 3'd5
    } state_t;

    state_t                      state_q;
    logic [OPCODE_SIZE-1:0]      op_q;
    logic [DATA_SIZE-1:0]        data_q;
    logic [DATA_SIZE-1:0]        cnt_q;
    logic                        cs_q;
    logic                        rd_q;
    logic                        wr_q;
    logic [ADDRESS_SIZE-1:0]     addr_q;
    logic [DATA_SIZE-1:0]        wdata_q;
    logic [DATA_SIZE-1:0]        rdw_q;
    logic [INSTR_LIMIT_SIZE-1:0] pc_q;
    logic                        ready_q;
    logic                        err_flag_q;
    logic [ERR_CNT_SIZE-1:0]     err_cnt_q;

    // Field views of the combinational table entry at the current PC.
    logic [OPCODE_SIZE-1:0]  fetch_op;
    logic [ADDRESS_SIZE-1:0] fetch_addr;
    logic [DATA_SIZE-1:0]    fetch_data;

    assign fetch_op   = instructionVector[INSTR_SIZE-1 -: OPCODE_SIZE];
    assign fetch_addr = instructionVector[DATA_SIZE +: ADDRESS_SIZE];
    assign fetch_data = instructionVector[DATA_SIZE-1:0];

    // Common "instruction retired" step.
    // The last table entry never wraps the PC; it falls into HALT instead.
    state_t                      adv_state_d;
    logic [INSTR_LIMIT_SIZE-1:0] adv_pc_d;
    logic                        adv_ready_d;
    logic [ERR_CNT_SIZE-1:0]     err_cnt_d;
    logic                        rd_mismatch;

    // Next PC/state after retiring an instruction, and saturating error count.
    always_comb begin
        adv_state_d = S_FETCH;
        adv_pc_d    = pc_q + 1'b1;
        adv_ready_d = 1'b0;
        if (&pc_q) begin
            adv_state_d = S_HALT;
            adv_pc_d    = pc_q;
            adv_ready_d = 1'b1;
        end
        err_cnt_d   = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;
        rd_mismatch = (avm.avmaster_readdata != data_q);
    end

    // Sequencer FSM with registered bus and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            op_q       <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            cs_q       <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdw_q      <= '0;
            pc_q       <= '0;
            ready_q    <= 1'b0;
            err_flag_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    op_q   <= fetch_op;
                    data_q <= fetch_data;
                    case (fetch_op)
                        OP_NOP: begin
                            pc_q    <= adv_pc_d;
                            state_q <= adv_state_d;
                            ready_q <= adv_ready_d;
                        end
                        OP_WRITE: begin
                            cs_q    <= 1'b1;
                            wr_q    <= 1'b1;
                            addr_q  <= fetch_addr;
                            wdata_q <= fetch_data;
                            state_q <= S_WRITE;
                        end
                        OP_READ, OP_READ_CHECK: begin
                            cs_q    <= 1'b1;
                            rd_q    <= 1'b1;
                            addr_q  <= fetch_addr;
                            cnt_q   <= READ_WAIT_CNT;
                            state_q <= S_READ;
                        end
                        OP_WAIT_IRQ: begin
                            cnt_q   <= fetch_data;
                            state_q <= S_WAIT_IRQ;
                        end
                        OP_DELAY: begin
                            cnt_q   <= fetch_data;
                            state_q <= S_DELAY;
                        end
                        OP_HALT: begin
                            state_q <= S_HALT;
                            ready_q <= 1'b1;
                        end
                        default: begin
                            err_flag_q <= 1'b1;
                            state_q    <= S_HALT;
                            ready_q    <= 1'b1;
                        end
                    endcase
                end

                S_WRITE: begin
                    cs_q    <= 1'b0;
                    wr_q    <= 1'b0;
                    pc_q    <= adv_pc_d;
                    state_q <= adv_state_d;
                    ready_q <= adv_ready_d;
                end

                // cnt_q counts the remaining wait states.
                // Zero marks the cycle on which readdata is valid.
                S_READ: begin
                    if (cnt_q == '0) begin
                        cs_q  <= 1'b0;
                        rd_q  <= 1'b0;
                        rdw_q <= avm.avmaster_readdata;
                        if (op_q == OP_READ_CHECK && rd_mismatch) begin
                            err_cnt_q  <= err_cnt_d;
                            err_flag_q <= 1'b1;
                        end
                        pc_q    <= adv_pc_d;
                        state_q <= adv_state_d;
                        ready_q <= adv_ready_d;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                // A zero timeout waits forever; otherwise cnt_q counts down the
                // remaining cycles and the last one flags a timeout.
                S_WAIT_IRQ: begin
                    if (avm.avmaster_irq) begin
                        pc_q    <= adv_pc_d;
                        state_q <= adv_state_d;
                        ready_q <= adv_ready_d;
                    end else if (data_q != '0) begin
                        if (cnt_q == CNT_ONE) begin
                            err_flag_q <= 1'b1;
                            pc_q       <= adv_pc_d;
                            state_q    <= adv_state_d;
                            ready_q    <= adv_ready_d;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end

                // Counts of 0 and 1 both end after a single idle cycle.
                S_DELAY: begin
                    if (cnt_q <= CNT_ONE) begin
                        pc_q    <= adv_pc_d;
                        state_q <= adv_state_d;
                        ready_q <= adv_ready_d;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                S_HALT: begin
                    cs_q <= 1'b0;
                    rd_q <= 1'b0;
                    wr_q <= 1'b0;
                end

                default: begin
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

    assign avm.avmaster_chipselect = cs_q;
    assign avm.avmaster_read       = rd_q;
    assign avm.avmaster_write      = wr_q;
    assign avm.avmaster_address    = addr_q;
    assign avm.avmaster_writedata  = wdata_q;
    assign readdataWatch           = rdw_q;
    assign programCounter          = pc_q;
    assign simReady                = ready_q;
    assign errorFlag               = err_flag_q;
    assign errorCount              = err_cnt_q;
    assign dbg_state_o             = state_q;

endmodule
